// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The optional HAZARD_STATS_EN build adds stall-cause counters.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W_DEF      = 5;
    localparam int unsigned MULDIV_LAT_DEF = 4;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned FWD_W          = 2;
    localparam int unsigned STAT_W         = 16;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath side.
// Stall counters appear only when HAZARD_STATS_EN is defined.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             ID_muldiv;
    logic             ID_reads_hilo;
    logic [REG_W-1:0] EX_rd_dest;
    logic             EX_rf_enable;
    logic             EX_load;
    logic [REG_W-1:0] MEM_rd_dest;
    logic             MEM_rf_enable;
    logic [REG_W-1:0] WB_rd_dest;
    logic             WB_rf_enable;

    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             pc_ld;
    logic             ifid_ld;
    logic             idex_bubble;
    logic             muldiv_issue;
    logic             hilo_we;
    logic             muldiv_busy;
`ifdef HAZARD_STATS_EN
    logic [15:0]      stall_load_cnt;
    logic [15:0]      stall_muldiv_cnt;
`endif

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv, ID_reads_hilo,
               EX_rd_dest, EX_rf_enable, EX_load, MEM_rd_dest, MEM_rf_enable,
               WB_rd_dest, WB_rf_enable,
`ifdef HAZARD_STATS_EN
        input  stall_load_cnt, stall_muldiv_cnt,
`endif
        input  fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_bubble,
               muldiv_issue, hilo_we, muldiv_busy
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_muldiv, ID_reads_hilo,
               EX_rd_dest, EX_rf_enable, EX_load, MEM_rd_dest, MEM_rf_enable,
               WB_rd_dest, WB_rf_enable,
`ifdef HAZARD_STATS_EN
        output stall_load_cnt, stall_muldiv_cnt,
`endif
        output fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_bubble,
               muldiv_issue, hilo_we, muldiv_busy
    );
endinterface

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// Operand forwarding select for one ALU input; youngest writer wins.
module fwd_unit
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] operand,
    input  logic             used,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_we,
    output logic [FWD_W-1:0] sel
);
    logic nonzero;

    assign nonzero = (operand != '0);

    // A load in EX has no data yet, so it never forwards; the stall covers it.
    always_comb begin
        sel = FWD_RF;
        if (used && nonzero) begin
            if (ex_we && !ex_load && (ex_dest == operand)) begin
                sel = FWD_EX;
            end else if (mem_we && (mem_dest == operand)) begin
                sel = FWD_MEM;
            end else if (wb_we && (wb_dest == operand)) begin
                sel = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline controller: forwarding, load-use and HI/LO structural stalls, mult/div scheduling.
// Defining HAZARD_STATS_EN adds saturating per-cause stall counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int unsigned REG_W      = REG_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_c;
    logic             load_use_c;
    logic             struct_stall_c;
    logic             stall_c;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .operand  (bus.ID_rs),
        .used     (bus.ID_uses_rs),
        .ex_dest  (bus.EX_rd_dest),
        .ex_we    (bus.EX_rf_enable),
        .ex_load  (bus.EX_load),
        .mem_dest (bus.MEM_rd_dest),
        .mem_we   (bus.MEM_rf_enable),
        .wb_dest  (bus.WB_rd_dest),
        .wb_we    (bus.WB_rf_enable),
        .sel      (bus.fwd_a_sel)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .operand  (bus.ID_rt),
        .used     (bus.ID_uses_rt),
        .ex_dest  (bus.EX_rd_dest),
        .ex_we    (bus.EX_rf_enable),
        .ex_load  (bus.EX_load),
        .mem_dest (bus.MEM_rd_dest),
        .mem_we   (bus.MEM_rf_enable),
        .wb_dest  (bus.WB_rd_dest),
        .wb_we    (bus.WB_rf_enable),
        .sel      (bus.fwd_b_sel)
    );

    assign busy_c     = (state_q == BUSY);
    assign load_use_c = bus.EX_load && bus.EX_rf_enable && (bus.EX_rd_dest != '0) &&
                        ((bus.ID_uses_rs && (bus.ID_rs == bus.EX_rd_dest)) ||
                         (bus.ID_uses_rt && (bus.ID_rt == bus.EX_rd_dest)));
    assign struct_stall_c = (bus.ID_muldiv || bus.ID_reads_hilo) && busy_c;
    assign stall_c        = load_use_c || struct_stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The issue cycle is the first latency cycle, so the HI/LO write lands MULDIV_LAT-1 cycles later.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        bus.muldiv_issue = 1'b0;
        bus.hilo_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ID_muldiv && !stall_c) begin
                    bus.muldiv_issue = 1'b1;
                    state_d          = BUSY;
                    count_d          = CNT_W'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    bus.hilo_we = 1'b1;
                    state_d     = IDLE;
                    count_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.pc_ld       = !stall_c;
        bus.ifid_ld     = !stall_c;
        bus.idex_bubble = stall_c;
        bus.muldiv_busy = busy_c;
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] ld_cnt_q;
    logic [STAT_W-1:0] md_cnt_q;

    // Saturating counters; a cycle with both causes bumps both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            if (load_use_c && (ld_cnt_q != '1)) ld_cnt_q <= ld_cnt_q + STAT_W'(1);
            if (struct_stall_c && (md_cnt_q != '1)) md_cnt_q <= md_cnt_q + STAT_W'(1);
        end
    end

    assign bus.stall_load_cnt   = ld_cnt_q;
    assign bus.stall_muldiv_cnt = md_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random traffic vs a cycle-index model.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5)) bus ();

    hazard_stall_ctrl #(.MULDIV_LAT(LAT), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] rs, rt, exd, memd, wbd;
        bit         urs, urt, md, rh, exwe, exld, memwe, wbwe;
    } stim_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       pc, ifid, bub, iss, hwe, busy;
    } exp_t;

    exp_t  sbq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    issue_cyc   = -1000;
    int    n_ld        = 0;
    int    n_md        = 0;
    stim_t z;

    // Forwarding rule: nearest writer of a nonzero register, loads in EX excluded.
    function automatic logic [1:0] ref_fwd(input logic [4:0] op, input bit used, input stim_t s);
        if (!used || op == 5'd0) return 2'b00;
        if (s.exwe && !s.exld && s.exd == op) return 2'b01;
        if (s.memwe && s.memd == op) return 2'b10;
        if (s.wbwe && s.wbd == op) return 2'b11;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s, input bit rst);
        exp_t e;
        bit   busy, lu, sh, st;
        @(posedge clk);
        cyc++;
        #1;
        reset = rst ? 1'b0 : 1'b1;
        bus.ID_rs = s.rs;  bus.ID_rt = s.rt;
        bus.ID_uses_rs = s.urs; bus.ID_uses_rt = s.urt;
        bus.ID_muldiv = s.md; bus.ID_reads_hilo = s.rh;
        bus.EX_rd_dest = s.exd; bus.EX_rf_enable = s.exwe; bus.EX_load = s.exld;
        bus.MEM_rd_dest = s.memd; bus.MEM_rf_enable = s.memwe;
        bus.WB_rd_dest = s.wbd; bus.WB_rf_enable = s.wbwe;
        if (rst) begin
            issue_cyc = -1000;
            n_ld = 0;
            n_md = 0;
        end
        // HI/LO unit occupied from the cycle after issue through the write cycle.
        busy = (cyc > issue_cyc) && (cyc <= issue_cyc + LAT - 1);
        lu   = s.exld && s.exwe && s.exd != 5'd0 &&
               ((s.urs && s.rs == s.exd) || (s.urt && s.rt == s.exd));
        sh   = (s.md || s.rh) && busy;
        st   = lu || sh;
        e.fa   = ref_fwd(s.rs, s.urs, s);
        e.fb   = ref_fwd(s.rt, s.urt, s);
        e.pc   = !st;
        e.ifid = !st;
        e.bub  = st;
        e.busy = busy;
        e.hwe  = busy && (cyc == issue_cyc + LAT - 1);
        e.iss  = s.md && !st && !busy;
        if (e.iss) issue_cyc = cyc;
        if (!rst && lu) n_ld++;
        if (!rst && sh) n_md++;
        sbq.push_back(e);
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.rs = 5'($urandom_range(0, 7));   s.rt = 5'($urandom_range(0, 7));
        s.exd = 5'($urandom_range(0, 7));  s.memd = 5'($urandom_range(0, 7));
        s.wbd = 5'($urandom_range(0, 7));
        s.urs = $urandom_range(0, 3) != 0; s.urt = $urandom_range(0, 3) != 0;
        s.md = $urandom_range(0, 6) == 0;  s.rh = $urandom_range(0, 5) == 0;
        s.exwe = $urandom_range(0, 2) != 0; s.exld = $urandom_range(0, 2) == 0;
        s.memwe = $urandom_range(0, 2) != 0; s.wbwe = $urandom_range(0, 2) != 0;
        return s;
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {bus.fwd_a_sel, bus.fwd_b_sel, bus.pc_ld, bus.ifid_ld, bus.idex_bubble,
                 bus.muldiv_issue, bus.hilo_we, bus.muldiv_busy};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d got fa=%b fb=%b pc=%b ifid=%b bub=%b iss=%b hwe=%b busy=%b expected fa=%b fb=%b pc=%b ifid=%b bub=%b iss=%b hwe=%b busy=%b",
                         cyc, a.fa, a.fb, a.pc, a.ifid, a.bub, a.iss, a.hwe, a.busy,
                         e.fa, e.fb, e.pc, e.ifid, e.bub, e.iss, e.hwe, e.busy);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        stim_t s;
        int    guard;
        z = '{default: 0};
        reset = 1'b0;
        bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_uses_rs = 0; bus.ID_uses_rt = 0;
        bus.ID_muldiv = 0; bus.ID_reads_hilo = 0; bus.EX_rd_dest = '0;
        bus.EX_rf_enable = 0; bus.EX_load = 0; bus.MEM_rd_dest = '0;
        bus.MEM_rf_enable = 0; bus.WB_rd_dest = '0; bus.WB_rf_enable = 0;

        repeat (3) apply(z, 1'b1);

        // EX beats MEM; $0 never forwards
        s = z; s.rs = 5; s.urs = 1; s.exd = 5; s.exwe = 1; s.memd = 5; s.memwe = 1;
        apply(s, 1'b0);
        s.rs = 0; s.exd = 0;
        apply(s, 1'b0);

        // lw $8 then consumer of rt=$8
        s = z; s.rt = 8; s.urt = 1; s.exd = 8; s.exwe = 1; s.exld = 1;
        apply(s, 1'b0);
        s = z; s.rt = 8; s.urt = 1; s.memd = 8; s.memwe = 1;
        apply(s, 1'b0);

        // mult then mfhi
        s = z; s.md = 1;
        apply(s, 1'b0);
        s = z; s.rh = 1;
        repeat (LAT) apply(s, 1'b0);
        apply(z, 1'b0);

        // mult while busy plus load-use on the waiting mult's operand
        s = z; s.md = 1;
        apply(s, 1'b0);
        s = z; s.md = 1; s.urs = 1; s.rs = 3; s.exd = 3; s.exwe = 1; s.exld = 1;
        repeat (LAT + 1) apply(s, 1'b0);
        s.exld = 0; s.exwe = 0;
        apply(s, 1'b0);
        repeat (LAT) apply(z, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) apply(z, 1'b1);
            else apply(rnd(), 1'b0);
        end
        repeat (LAT) apply(z, 1'b0);

        // reset while BUSY with two cycles left: unit must drop immediately
        s = z; s.md = 1;
        apply(s, 1'b0);
        apply(z, 1'b0);
        apply(z, 1'b1);
        #1;
        vectors++;
        if (bus.muldiv_busy !== 1'b0 || bus.hilo_we !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset busy=%b hwe=%b expected 0 0", bus.muldiv_busy, bus.hilo_we);
        end
        repeat (LAT) apply(z, 1'b1);
        repeat (3) apply(z, 1'b0);

`ifdef HAZARD_STATS_EN
        s = z; s.rt = 8; s.urt = 1; s.exd = 8; s.exwe = 1; s.exld = 1;
        apply(s, 1'b0);
        s = z; s.md = 1;
        apply(s, 1'b0);
        s = z; s.rh = 1;
        repeat (LAT) apply(s, 1'b0);
        repeat (2) apply(z, 1'b0);
`endif

        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end

`ifdef HAZARD_STATS_EN
        vectors++;
        if (bus.stall_load_cnt !== 16'(n_ld) || bus.stall_muldiv_cnt !== 16'(n_md)) begin
            miscompares++;
            $display("FAIL stall_counts got ld=%0d md=%0d expected ld=%0d md=%0d",
                     bus.stall_load_cnt, bus.stall_muldiv_cnt, n_ld, n_md);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
